// File: rtl/clock_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// clock_display_mux_pkg
// Shared definitions for the chess-clock display multiplexer:
//   - active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - clock_time_t : packed {min[2:0], sec1[2:0], sec2[3:0]} countdown word
//   - digit_idx_e  : the eight display positions, an[7]..an[0]
//   - digit_pos_e  : position of a digit inside one player's half
//   - is_low_time(): "under ten seconds, not yet flagged" test
// -----------------------------------------------------------------------------
package clock_display_mux_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [6:0] SEG_E      = 7'b0000110;
    localparam logic [6:0] SEG_DIGIT0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT3 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT4 = 7'b0011001;
    localparam logic [6:0] SEG_DIGIT5 = 7'b0010010;
    localparam logic [6:0] SEG_DIGIT6 = 7'b0000010;
    localparam logic [6:0] SEG_DIGIT7 = 7'b1111000;
    localparam logic [6:0] SEG_DIGIT8 = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT9 = 7'b0010000;

    // Field layout of the timer's packed countdown word.
    typedef struct packed {
        logic [2:0] min;
        logic [2:0] sec1;
        logic [3:0] sec2;
    } clock_time_t;

    // Display positions; white occupies the upper nibble of an, black the lower.
    typedef enum logic [2:0] {
        IDX_B_SEC2 = 3'd0,
        IDX_B_SEC1 = 3'd1,
        IDX_B_MIN  = 3'd2,
        IDX_B_TURN = 3'd3,
        IDX_W_SEC2 = 3'd4,
        IDX_W_SEC1 = 3'd5,
        IDX_W_MIN  = 3'd6,
        IDX_W_TURN = 3'd7
    } digit_idx_e;

    // Low two bits of digit_idx_e select the digit role within a half.
    typedef enum logic [1:0] {
        POS_SEC2 = 2'd0,
        POS_SEC1 = 2'd1,
        POS_MIN  = 2'd2,
        POS_TURN = 2'd3
    } digit_pos_e;

    // True when a running clock is inside its final seconds (0:0x, x != 0).
    function automatic logic is_low_time(input clock_time_t t);
        return (t.min == 3'd0) && (t.sec1 == 3'd0) && (t.sec2 != 4'd0);
    endfunction

endpackage

// File: rtl/clock_display_mux_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD -> active-low 7-segment decoder. Values 10..15 show 'E'.
// Ports:
//   value  in  4  digit value
//   seg    out 7  pattern {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import clock_display_mux_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        case (value)
            4'd0:    seg = SEG_DIGIT0;
            4'd1:    seg = SEG_DIGIT1;
            4'd2:    seg = SEG_DIGIT2;
            4'd3:    seg = SEG_DIGIT3;
            4'd4:    seg = SEG_DIGIT4;
            4'd5:    seg = SEG_DIGIT5;
            4'd6:    seg = SEG_DIGIT6;
            4'd7:    seg = SEG_DIGIT7;
            4'd8:    seg = SEG_DIGIT8;
            4'd9:    seg = SEG_DIGIT9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/clock_display_mux.sv
// -----------------------------------------------------------------------------
// clock_display_mux
// Drives an 8-digit multiplexed common-anode 7-segment display from the two
// chess-clock countdowns. Layout an[7]..an[0]:
//   [W-turn][Wmin][Wsec1][Wsec2][B-turn][Bmin][Bsec1][Bsec2]
// Each digit slot lasts REFRESH_DIV cycles; the first GUARD_CYC cycles of a
// slot keep all anodes off to avoid ghosting. Inputs are snapshotted once per
// frame (at the wrap back to the W-turn digit) so a frame never tears.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot
//   GUARD_CYC    dark cycles at the start of each slot (< REFRESH_DIV)
//   BLINK_DIV    clk cycles per blink half-period (low-time blink build only)
// Ports:
//   clk             in   1   system clock
//   rst             in   1   synchronous reset, active-high
//   countdownWhite  in  10   white time {min,sec1,sec2}
//   countdownBlack  in  10   black time {min,sec1,sec2}
//   turn            in   1   side to move: 0 = white, 1 = black
//   an              out  8   digit anodes, active-low, at most one low
//   seg             out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp              out  1   decimal point, active-low (colon after minutes)
// Configuration:
//   LOW_TIME_BLINK_EN  when defined, the mover's time digits blink while the
//                      mover shows 0:0x with x != 0.
// -----------------------------------------------------------------------------
module clock_display_mux
    import clock_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 64,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] countdownWhite,
    input  logic [9:0] countdownBlack,
    input  logic       turn,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [SLOT_W-1:0] slot_cnt;
    digit_idx_e        idx;
    clock_time_t       snap_white;
    clock_time_t       snap_black;
    logic              snap_turn;
    logic              snap_pending;   // forces a capture on the first cycle after reset

    logic              slot_wrap;
    logic              frame_wrap;
    logic              in_guard;
    logic              blink_blank;

    assign slot_wrap  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_wrap && (idx == IDX_B_SEC2);
    assign in_guard   = (slot_cnt < SLOT_W'(GUARD_CYC));

    // -------------------------------------------------------------------------
    // Prescaler, digit index and frame snapshot
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking writes would let a later statement
    // in this block see the already-updated slot counter or index.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            idx          <= IDX_W_TURN;
            snap_white   <= '0;
            snap_black   <= '0;
            snap_turn    <= 1'b0;
            snap_pending <= 1'b1;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= digit_idx_e'(idx - 3'd1);   // 0 wraps to 7
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (snap_pending || frame_wrap) begin
                snap_white <= clock_time_t'(countdownWhite);
                snap_black <= clock_time_t'(countdownBlack);
                snap_turn  <= turn;
            end
            snap_pending <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Optional low-time blink
    // -------------------------------------------------------------------------
`ifdef LOW_TIME_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Zero time is excluded by is_low_time, so a flagged clock stays steady.
    assign blink_blank = !blink_on &&
                         is_low_time(snap_turn ? snap_black : snap_white);
`else
    assign blink_blank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Digit select and decode
    // -------------------------------------------------------------------------
    clock_time_t cur_time;
    digit_pos_e  cur_pos;
    logic        white_half;
    logic        side_moves;
    logic [3:0]  dec_in;
    logic [6:0]  dec_seg;

    assign white_half = idx[2];
    assign cur_time   = white_half ? snap_white : snap_black;
    assign cur_pos    = digit_pos_e'(idx[1:0]);
    assign side_moves = (white_half != snap_turn);   // white moves on turn=0

    // NOTE: every signal driven in an always_comb gets a default at the top;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        dec_in = 4'd0;
        case (cur_pos)
            POS_MIN:  dec_in = {1'b0, cur_time.min};
            // Tens of seconds only goes to 5; larger values are forced into
            // the decoder's error range.
            POS_SEC1: dec_in = (cur_time.sec1 > 3'd5) ? 4'hF : {1'b0, cur_time.sec1};
            POS_SEC2: dec_in = cur_time.sec2;
            default:  dec_in = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .value (dec_in),
        .seg   (dec_seg)
    );

    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    always_comb begin
        an_next  = 8'hFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!in_guard) begin
            an_next = ~(8'd1 << idx);
            case (cur_pos)
                POS_TURN: seg_next = side_moves ? SEG_DASH : SEG_BLANK;
                POS_MIN: begin
                    seg_next = dec_seg;
                    dp_next  = 1'b0;
                end
                default:  seg_next = dec_seg;
            endcase
            if (blink_blank && side_moves && (cur_pos != POS_TURN)) begin
                seg_next = SEG_BLANK;
                dp_next  = 1'b1;
            end
        end
    end

    // Registering an alongside seg/dp keeps the anode aligned with its pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// -----------------------------------------------------------------------------
// tb_clock_display_mux
// Scoreboard bench: a reference model derives the expected display output from
// the absolute cycle count since reset and a per-frame copy of the inputs, and
// queues it each clock; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_clock_display_mux;

    localparam int R     = 8;
    localparam int G     = 2;
    localparam int B     = 32;
    localparam int FRAME = 8 * R;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cw  = '0;
    logic [9:0] cb  = '0;
    logic       turn = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    clock_display_mux #(
        .REFRESH_DIV (R),
        .GUARD_CYC   (G),
        .BLINK_DIV   (B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .countdownWhite (cw),
        .countdownBlack (cb),
        .turn           (turn),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_seg;
        int         pos;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] pat_e     = 7'h06;
    logic [6:0] pat_dash  = 7'h3F;
    logic [6:0] pat_blank = 7'h7F;

    logic [9:0] m_white = '0;
    logic [9:0] m_black = '0;
    logic       m_turn  = 1'b0;
    int         j       = 0;

    function automatic exp_t expect_at(input int jj, input logic [9:0] w,
                                       input logic [9:0] b, input logic t);
        exp_t e;
        int   slot, pos, role;
        bit   white_side, mover;
        logic [9:0] tv;
        int   mn, s1, s2;
        slot = jj % R;
        pos  = 7 - ((jj / R) % 8);
        e.pos = pos;
        e.an = 8'hFF; e.seg = pat_blank; e.dp = 1'b1; e.chk_seg = 1'b0;
        if (slot >= G) begin
            e.chk_seg  = 1'b1;
            e.an       = ~(8'd1 << pos);
            white_side = (pos >= 4);
            tv         = white_side ? w : b;
            mn = int'(tv[9:7]); s1 = int'(tv[6:4]); s2 = int'(tv[3:0]);
            mover = white_side ? (t == 1'b0) : (t == 1'b1);
            role  = pos % 4;
            case (role)
                3: e.seg = mover ? pat_dash : pat_blank;
                2: begin e.seg = pat[mn]; e.dp = 1'b0; end
                1: e.seg = (s1 > 5) ? pat_e : pat[s1];
                default: e.seg = (s2 > 9) ? pat_e : pat[s2];
            endcase
`ifdef LOW_TIME_BLINK_EN
            if (role != 3 && mover && mn == 0 && s1 == 0 && s2 != 0 && ((jj / B) % 2 == 1)) begin
                e.seg = pat_blank;
                e.dp  = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            e.an = 8'hFF; e.seg = pat_blank; e.dp = 1'b1; e.chk_seg = 1'b1; e.pos = -1;
            exp_q.push_back(e);
            j = 0;
            m_white = '0; m_black = '0; m_turn = 1'b0;
        end else begin
            exp_q.push_back(expect_at(j, m_white, m_black, m_turn));
            if (j == 0 || (j % FRAME) == FRAME - 1) begin
                m_white = cw; m_black = cb; m_turn = turn;
            end
            j++;
        end
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("an(pos %0d)", e.pos), 32'(an), 32'(e.an));
            if (e.chk_seg) begin
                check($sformatf("seg(pos %0d)", e.pos), 32'(seg), 32'(e.seg));
                check($sformatf("dp(pos %0d)", e.pos), 32'(dp), 32'(e.dp));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    function automatic logic [9:0] rand_time();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3)      return {3'd0, 3'd0, 4'($urandom_range(0, 15))};
        else if (sel < 4) return 10'd0;
        else              return 10'($urandom_range(0, 1023));
    endfunction

    initial begin
        rst = 1'b1;
        cw  = {3'd4, 3'd5, 4'd9};
        cb  = {3'd3, 3'd0, 4'd7};
        turn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Full frame, then a mid-frame change that must wait for the next frame.
        repeat (FRAME + 3 * R + 3) @(negedge clk);
        cw = {3'd4, 3'd5, 4'd8};
        repeat (2 * FRAME) @(negedge clk);

        // Out-of-range seconds digits.
        cb = {3'd2, 3'd4, 4'd12};
        cw = {3'd1, 3'd6, 4'd3};
        repeat (2 * FRAME) @(negedge clk);

        // Black to move in its final seconds, then flagged, then both flagged.
        turn = 1'b1;
        cb   = {3'd0, 3'd0, 4'd7};
        repeat (4 * FRAME) @(negedge clk);
        cb = 10'd0;
        repeat (2 * FRAME) @(negedge clk);
        cw = 10'd0;
        repeat (2 * FRAME) @(negedge clk);

        // Reset in the middle of digit slot 4; scan must restart at index 7.
        cw = {3'd7, 3'd2, 4'd1};
        cb = {3'd5, 3'd3, 4'd6};
        for (int k = 0; k < FRAME && ((j % FRAME) / R) != 3; k++) @(negedge clk);
        repeat (R / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 40; n++) begin
            cw   = rand_time();
            cb   = rand_time();
            turn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
